// File: rtl/s1423_test_pkg.sv
// Shared types and default constants for the s1423 output-cone SISR stage.
package s1423_test_pkg;

    localparam int unsigned SISR_W    = 16;
    localparam logic [15:0] SISR_POLY = 16'h1021;
    localparam logic [15:0] SISR_SEED = 16'hFFFF;

    localparam int unsigned PAT_W = 16;

    typedef logic [PAT_W-1:0] pat_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sisr_state_t;

endpackage

// File: rtl/sisr_core.sv
// W-bit serial-input signature register: Galois-style shift with polynomial
// feedback, XOR-ing one serial bit into stage 0 on every shift.
module sisr_core #(
    parameter int unsigned W       = 16,
    parameter logic [W-1:0] POLY   = W'(16'h1021),
    parameter logic [W-1:0] RST_VAL = W'(16'hFFFF)
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         shift,
    input  logic         din,
    output logic [W-1:0] q
);

    logic [W-1:0] step_c;

    // Next signature for one compacted sample.
    always_comb begin
        step_c = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ {{(W-1){1'b0}}, din};
    end

    // Load has priority over shift; otherwise the register holds.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= seed;
        end else if (shift) begin
            q <= step_c;
        end
    end

endmodule

// File: rtl/s1423_n90_sisr.sv
// SISR compaction stage for s1423 cone output n90: run-control FSM, pattern
// counter and signature register. Optional macro S1423_SISR_CMP_EN adds a
// registered golden-signature comparator (golden input, pass output).
module s1423_n90_sisr
    import s1423_test_pkg::*;
#(
    parameter int unsigned  W    = SISR_W,
    parameter logic [W-1:0] POLY = W'(SISR_POLY),
    parameter logic [W-1:0] SEED = W'(SISR_SEED)
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         start,
    input  logic [15:0]  npat,
    input  logic         n90,
    input  logic         n90_vld,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sig,
    output logic [15:0]  count
`ifdef S1423_SISR_CMP_EN
    ,
    input  logic [W-1:0] golden,
    output logic         pass
`endif
);

    sisr_state_t state;
    pat_cnt_t    npat_q;

    logic start_acc_c;
    logic shift_c;
    logic last_c;

    // Start is honoured only outside RUN; samples only count inside RUN.
    always_comb begin
        start_acc_c = start && (state != RUN);
        shift_c     = (state == RUN) && n90_vld;
        last_c      = (count == 16'(npat_q - 16'd1));
    end

    sisr_core #(
        .W       (W),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_core (
        .CK    (CK),
        .RN    (RN),
        .load  (start_acc_c),
        .seed  (SEED),
        .shift (shift_c),
        .din   (n90),
        .q     (sig)
    );

    // Run-control FSM with the pattern counter and registered status flags.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            count  <= '0;
            npat_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count  <= '0;
                        npat_q <= npat;
                        if (npat == 16'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (n90_vld) begin
                        count <= 16'(count + 16'd1);
                        if (last_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef S1423_SISR_CMP_EN
    logic         enter_done_c;
    logic [W-1:0] final_c;

    // Signature as it will stand on the edge that enters DONE.
    always_comb begin
        enter_done_c = (start_acc_c && (npat == 16'd0)) || (shift_c && last_c);
        if (start_acc_c) begin
            final_c = SEED;
        end else begin
            final_c = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0)
                    ^ {{(W-1){1'b0}}, n90};
        end
    end

    // Pass verdict captured on DONE entry, cleared by an accepted start.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pass <= 1'b0;
        end else if (enter_done_c) begin
            pass <= (final_c == golden);
        end else if (start_acc_c) begin
            pass <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_s1423_n90_sisr.sv
// Directed self-checking bench for s1423_n90_sisr (default and SEED=0 builds).
module tb_s1423_n90_sisr;

    logic        CK;
    logic        RN;
    logic        start;
    logic [15:0] npat;
    logic        n90;
    logic        n90_vld;
    logic        busy, done;
    logic [15:0] sig, count;
    logic        busy_z, done_z;
    logic [15:0] sig_z, count_z;
    logic [15:0] golden;
    logic        pass, pass_z;

    int tests;
    int failed;

    s1423_n90_sisr dut (
        .CK(CK), .RN(RN), .start(start), .npat(npat), .n90(n90), .n90_vld(n90_vld),
        .busy(busy), .done(done), .sig(sig), .count(count)
`ifdef S1423_SISR_CMP_EN
        , .golden(golden), .pass(pass)
`endif
    );

    s1423_n90_sisr #(.SEED(16'h0000)) dut_z (
        .CK(CK), .RN(RN), .start(start), .npat(npat), .n90(n90), .n90_vld(n90_vld),
        .busy(busy_z), .done(done_z), .sig(sig_z), .count(count_z)
`ifdef S1423_SISR_CMP_EN
        , .golden(golden), .pass(pass_z)
`endif
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        npat  = n;
        tick();
        start = 1'b0;
    endtask

    task automatic sample(input logic b);
        n90     = b;
        n90_vld = 1'b1;
        tick();
        n90_vld = 1'b0;
        n90     = 1'b0;
    endtask

    task automatic test_reset();
        RN = 1'b0;
        tick();
        tick();
        tests++; if (sig !== 16'hFFFF) begin failed++; $display("FAIL reset_sig: got %h want ffff", sig); end
        tests++; if (count !== 16'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
        tests++; if (sig_z !== 16'h0000) begin failed++; $display("FAIL reset_sig_seed0: got %h want 0000", sig_z); end
        RN = 1'b1;
        tick();
        sample(1'b1);
        tests++; if (sig !== 16'hFFFF || count !== 16'd0 || busy !== 1'b0) begin failed++; $display("FAIL idle_vld_ignored: sig=%h count=%0d busy=%b want ffff 0 0", sig, count, busy); end
    endtask

    task automatic test_single();
        golden = 16'hEFDE;
        do_start(16'd1);
        tests++; if (busy !== 1'b1 || done !== 1'b0 || sig !== 16'hFFFF || count !== 16'd0) begin failed++; $display("FAIL single_run_entry: busy=%b done=%b sig=%h count=%0d want 1 0 ffff 0", busy, done, sig, count); end
        sample(1'b1);
        tests++; if (sig !== 16'hEFDE) begin failed++; $display("FAIL single_sig: got %h want efde", sig); end
        tests++; if (count !== 16'd1 || done !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL single_done: count=%0d done=%b busy=%b want 1 1 0", count, done, busy); end
`ifdef S1423_SISR_CMP_EN
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL single_pass: got %b want 1", pass); end
`endif
        sample(1'b1);
        sample(1'b0);
        tests++; if (sig !== 16'hEFDE || count !== 16'd1 || done !== 1'b1) begin failed++; $display("FAIL done_frozen: sig=%h count=%0d done=%b want efde 1 1", sig, count, done); end
    endtask

    task automatic test_gap();
        do_start(16'd2);
        sample(1'b0);
        tests++; if (sig !== 16'hEFDF || count !== 16'd1) begin failed++; $display("FAIL gap_first: sig=%h count=%0d want efdf 1", sig, count); end
        start = 1'b1;
        npat  = 16'd5;
        tick();
        start = 1'b0;
        tests++; if (busy !== 1'b1 || sig !== 16'hEFDF || count !== 16'd1) begin failed++; $display("FAIL gap_hold: busy=%b sig=%h count=%0d want 1 efdf 1", busy, sig, count); end
        sample(1'b0);
        tests++; if (sig !== 16'hCF9F || count !== 16'd2 || done !== 1'b1) begin failed++; $display("FAIL gap_final: sig=%h count=%0d done=%b want cf9f 2 1", sig, count, done); end
    endtask

    task automatic test_zero();
        do_start(16'd0);
        tests++; if (done !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL zero_flags: done=%b busy=%b want 1 0", done, busy); end
        tests++; if (sig !== 16'hFFFF || count !== 16'd0) begin failed++; $display("FAIL zero_sig: sig=%h count=%0d want ffff 0", sig, count); end
        sample(1'b1);
        tests++; if (sig !== 16'hFFFF || done !== 1'b1) begin failed++; $display("FAIL zero_frozen: sig=%h done=%b want ffff 1", sig, done); end
    endtask

    task automatic test_seed0();
        do_start(16'd8);
        for (int i = 0; i < 8; i++) sample(1'b0);
        tests++; if (sig_z !== 16'h0000 || count_z !== 16'd8 || done_z !== 1'b1) begin failed++; $display("FAIL seed0_run: sig=%h count=%0d done=%b want 0000 8 1", sig_z, count_z, done_z); end
        do_start(16'd1);
        tests++; if (count_z !== 16'd0 || busy_z !== 1'b1 || done_z !== 1'b0) begin failed++; $display("FAIL seed0_restart: count=%0d busy=%b done=%b want 0 1 0", count_z, busy_z, done_z); end
        sample(1'b0);
        tests++; if (sig_z !== 16'h0000 || count_z !== 16'd1 || done_z !== 1'b1) begin failed++; $display("FAIL seed0_second: sig=%h count=%0d done=%b want 0000 1 1", sig_z, count_z, done_z); end
    endtask

    task automatic test_reset_mid();
        do_start(16'd5);
        for (int i = 0; i < 3; i++) sample(1'b1);
        tests++; if (count !== 16'd3 || busy !== 1'b1) begin failed++; $display("FAIL mid_progress: count=%0d busy=%b want 3 1", count, busy); end
        #2 RN = 1'b0;
        #1;
        tests++; if (sig !== 16'hFFFF || count !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL mid_abort: sig=%h count=%0d busy=%b done=%b want ffff 0 0 0", sig, count, busy, done); end
        tick();
        RN = 1'b1;
        tick();
        do_start(16'd1);
        sample(1'b1);
        tests++; if (sig !== 16'hEFDE || done !== 1'b1) begin failed++; $display("FAIL mid_rerun: sig=%h done=%b want efde 1", sig, done); end
    endtask

`ifdef S1423_SISR_CMP_EN
    task automatic test_pass();
        golden = 16'hEFDE;
        do_start(16'd1);
        sample(1'b1);
        tests++; if (pass !== 1'b1) begin failed++; $display("FAIL pass_match: got %b want 1", pass); end
        golden = 16'hEFDF;
        do_start(16'd1);
        tests++; if (pass !== 1'b0) begin failed++; $display("FAIL pass_clear_on_start: got %b want 0", pass); end
        sample(1'b1);
        tests++; if (pass !== 1'b0) begin failed++; $display("FAIL pass_mismatch: got %b want 0", pass); end
    endtask
`endif

    initial begin
        tests   = 0;
        failed  = 0;
        RN      = 1'b0;
        start   = 1'b0;
        npat    = 16'd0;
        n90     = 1'b0;
        n90_vld = 1'b0;
        golden  = 16'h0000;
        test_reset();
        test_single();
        test_gap();
        test_zero();
        test_seed0();
        test_reset_mid();
`ifdef S1423_SISR_CMP_EN
        test_pass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
